// File: rtl/ram_banked_if.sv
// ram_banked_if: write, read and clear bus of the banked RAM.
// The external address ports are `ADDR_W bits wide (default 11).
`ifndef ADDR_W
`define ADDR_W 11
`endif

interface ram_banked_if #(
  parameter int WIDTH  = 264,
  parameter int LANE_W = 8
);
  localparam int LANES = WIDTH / LANE_W;

  logic               i_clear;
  logic               o_busy;
  logic               i_we;
  logic [`ADDR_W-1:0] i_waddr;
  logic [WIDTH-1:0]   i_wdata;
  logic [LANES-1:0]   i_wmask;
  logic               i_re;
  logic [`ADDR_W-1:0] i_raddr;
  logic [WIDTH-1:0]   o_rdata;
  logic               o_rvalid;

  modport master (
    output i_clear, i_we, i_waddr, i_wdata,
    output i_wmask, i_re, i_raddr,
    input  o_busy, o_rdata, o_rvalid
  );

  modport slave (
    input  i_clear, i_we, i_waddr, i_wdata,
    input  i_wmask, i_re, i_raddr,
    output o_busy, o_rdata, o_rvalid
  );
endinterface

// File: rtl/ram_banked.sv
// ram_banked: banked SDP RAM, lane-masked writes, clear sweep.
// Define RAM_OUT_REG_EN for a second output register stage.
module ram_banked #(
  parameter int WIDTH  = 264,
  parameter int DEPTH  = 2048,
  parameter int BANKS  = 4,
  parameter int LANE_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic       i_clk,
  input logic       i_rst,
  ram_banked_if.slave bus
);
  localparam int ROWS   = DEPTH / BANKS;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int BANK_W = $clog2(BANKS);
  localparam int LANES  = WIDTH / LANE_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]       state;
  logic [ROW_W-1:0] ptr;
  logic [WIDTH-1:0] mem [BANKS][ROWS];

  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;
  logic [BANK_W-1:0] wbank;
  logic [BANK_W-1:0] rbank;
  logic [ROW_W-1:0]  wrow;
  logic [ROW_W-1:0]  rrow;
  logic              clr;
  logic              wr;
  logic              rd;

  logic [WIDTH-1:0] rdata1;
  logic             rvalid1;

  assign wa    = bus.i_waddr[ADDR_W-1:0];
  assign ra    = bus.i_raddr[ADDR_W-1:0];
  assign wbank = wa[BANK_W-1:0];
  assign rbank = ra[BANK_W-1:0];
  assign wrow  = wa[ADDR_W-1:BANK_W];
  assign rrow  = ra[ADDR_W-1:BANK_W];

  assign clr = (state == S_CLEAR) && !i_rst;
  assign wr  = (state == S_IDLE) && bus.i_we && !i_rst;
  assign rd  = (state == S_IDLE) && bus.i_re && !i_rst;

  assign bus.o_busy = (state == S_CLEAR);

  // Sweep sequencer: reset or clear pulse restarts at row 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_CLEAR): begin
          ptr <= ptr + 1'b1;
          if (ptr == ROW_W'(ROWS - 1))
            state <= S_IDLE;
        end
        (state == S_IDLE): begin
          if (bus.i_clear) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Array update: sweep zeroes one row of every bank per cycle
  always_ff @(posedge i_clk) begin
    if (clr) begin
      for (int b = 0; b < BANKS; b++)
        mem[b][ptr] <= '0;
    end else if (wr) begin
      for (int k = 0; k < LANES; k++)
        if (bus.i_wmask[k])
          mem[wbank][wrow][k*LANE_W +: LANE_W] <=
            bus.i_wdata[k*LANE_W +: LANE_W];
    end
  end

  // First read stage: old word returned on same-address write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata1  <= '0;
      rvalid1 <= 1'b0;
    end else if (rd) begin
      rdata1  <= mem[rbank][rrow];
      rvalid1 <= 1'b1;
    end else begin
      rvalid1 <= 1'b0;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [WIDTH-1:0] rdata2;
  logic             rvalid2;

  // Extra output stage for timing closure
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata2  <= '0;
      rvalid2 <= 1'b0;
    end else begin
      rdata2  <= rdata1;
      rvalid2 <= rvalid1;
    end
  end

  assign bus.o_rdata  = rdata2;
  assign bus.o_rvalid = rvalid2;
`else
  assign bus.o_rdata  = rdata1;
  assign bus.o_rvalid = rvalid1;
`endif
endmodule

// File: tb/tb_ram_banked.sv
// tb_ram_banked: directed and random checks of ram_banked
// against a word-level reference model.
module tb_ram_banked;
  localparam int W     = 264;
  localparam int DEPTH = 2048;
  localparam int ROWS  = 512;
  localparam int LANES = 33;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  ram_banked_if #(.WIDTH(W), .LANE_W(8)) bus ();

  ram_banked #(
    .WIDTH(W), .DEPTH(DEPTH), .BANKS(4), .LANE_W(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference model: whole-array clear, word-level reads/writes
  bit [W-1:0] mm [DEPTH];
  int         clr_left = 0;
  bit         v1 = 0, v2 = 0;
  bit [W-1:0] d1 = '0, d2 = '0;

  task automatic model_step();
    bit [W-1:0] old;
    int wa;
    int ra;
    if (rst) begin
      clr_left = ROWS;
      v1 = 0; v2 = 0; d1 = '0; d2 = '0;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      d2 = d1; v2 = v1;
      v1 = 0;
    end else begin
      ra = int'(bus.i_raddr) % DEPTH;
      wa = int'(bus.i_waddr) % DEPTH;
      old = mm[ra];
      if (bus.i_we)
        for (int k = 0; k < LANES; k++)
          if (bus.i_wmask[k]) mm[wa][k*8 +: 8] = bus.i_wdata[k*8 +: 8];
      d2 = d1; v2 = v1;
      if (bus.i_re) begin d1 = old; v1 = 1; end
      else v1 = 0;
      if (bus.i_clear) begin
        clr_left = ROWS;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // cycle compare
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("busy", W'(bus.o_busy), W'(clr_left > 0));
      chk("rvalid", W'(bus.o_rvalid), W'(LAT == 2 ? v2 : v1));
      chk("rdata", bus.o_rdata, LAT == 2 ? d2 : d1);
    end
  end

  function automatic logic [W-1:0] rword();
    logic [287:0] t;
    for (int j = 0; j < 9; j++) t[j*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic wr(input int a, input logic [W-1:0] d,
                    input logic [LANES-1:0] m);
    bus.i_we = 1; bus.i_waddr = 11'(a);
    bus.i_wdata = d; bus.i_wmask = m;
    @(negedge clk);
    bus.i_we = 0;
  endtask

  task automatic wait_rv(output logic [W-1:0] d, output int lat);
    lat = 1;
    while (!bus.o_rvalid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    d = bus.o_rdata;
  endtask

  task automatic rd(input int a, output logic [W-1:0] d, output int lat);
    bus.i_re = 1; bus.i_raddr = 11'(a);
    @(negedge clk);
    bus.i_re = 0;
    wait_rv(d, lat);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (bus.o_busy && n < 2000) begin
      n++;
      bus.i_we = 1'($urandom); bus.i_re = 1'($urandom);
      bus.i_waddr = 11'($urandom_range(0, 15));
      bus.i_raddr = 11'($urandom_range(0, 15));
      bus.i_wdata = rword(); bus.i_wmask = '1;
      @(negedge clk);
    end
    bus.i_we = 0; bus.i_re = 0;
  endtask

  logic [W-1:0] d, a_w, b_w;
  logic [W-1:0] c [3];
  logic [63:0]  m64;
  int lat, n;
  bit vs [4];
  logic [W-1:0] ds [4];

  initial begin
    rst = 1;
    bus.i_clear = 0; bus.i_we = 0; bus.i_re = 0;
    bus.i_waddr = '0; bus.i_raddr = '0;
    bus.i_wdata = '0; bus.i_wmask = '0;
    @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    rst = 0;

    // 1: power-on sweep length, then a top-address read
    busy_len(n);
    chk("t1_busy_len", W'(n), W'(512));
    rd(11'h7FF, d, lat);
    chk("t1_data", d, '0);
    chk("t1_lat", W'(lat), W'(LAT));

    // 2: full-mask write then read
    wr(3, {33{8'h5A}}, '1);
    rd(3, d, lat);
    chk("t2_data", d, {33{8'h5A}});
    chk("t2_lat", W'(lat), W'(LAT));

    // 3: lane-0-only write
    wr(7, '1, '1);
    wr(7, '0, 33'h1);
    rd(7, d, lat);
    chk("t3_data", d, {{32{8'hFF}}, 8'h00});

    // 4: read-first on same address
    a_w = rword(); b_w = rword();
    wr(10, a_w, '1);
    bus.i_we = 1; bus.i_waddr = 11'd10;
    bus.i_wdata = b_w; bus.i_wmask = '1;
    bus.i_re = 1; bus.i_raddr = 11'd10;
    @(negedge clk);
    bus.i_we = 0; bus.i_re = 0;
    wait_rv(d, lat);
    chk("t4_old", d, a_w);
    rd(10, d, lat);
    chk("t4_new", d, b_w);

    // 5: clear sweep ignores traffic and zeroes the array
    for (int i = 0; i < 16; i++) wr(i, rword(), '1);
    bus.i_clear = 1;
    @(negedge clk);
    bus.i_clear = 0;
    busy_len(n);
    chk("t5_busy_len", W'(n), W'(512));
    for (int i = 0; i < 16; i++) begin
      rd(i, d, lat);
      chk("t5_zero", d, '0);
    end

    // 5b: reset at sweep cycle 100 restarts the full sweep
    for (int i = 0; i < 16; i++) wr(i, rword(), '1);
    bus.i_clear = 1;
    @(negedge clk);
    bus.i_clear = 0;
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    busy_len(n);
    chk("t5_rst_busy_len", W'(n), W'(512));
    rd(5, d, lat);
    chk("t5_rst_zero", d, '0);

    // 6: back-to-back reads, no bubbles
    for (int i = 0; i < 3; i++) begin
      c[i] = rword();
      wr(i + 1, c[i], '1);
    end
    bus.i_re = 1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.i_raddr = 11'(i + 1);
      else bus.i_re = 0;
      @(negedge clk);
      vs[i] = bus.o_rvalid;
      ds[i] = bus.o_rdata;
    end
    bus.i_re = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_rvalid", W'(vs[i]),
          W'((i >= LAT - 1) && (i < LAT + 2)));
      if ((i >= LAT - 1) && (i < LAT + 2))
        chk("t6_data", ds[i], c[i - (LAT - 1)]);
    end

    // random traffic with occasional clear and reset
    for (int i = 0; i < 4000; i++) begin
      bus.i_we = 1'($urandom);
      bus.i_re = 1'($urandom);
      bus.i_waddr = ($urandom_range(0, 3) == 0) ?
        11'($urandom) : 11'($urandom_range(0, 31));
      bus.i_raddr = ($urandom_range(0, 3) == 0) ?
        11'($urandom) : 11'($urandom_range(0, 31));
      bus.i_wdata = rword();
      m64 = {$urandom, $urandom};
      bus.i_wmask = ($urandom_range(0, 3) == 0) ? '1 : m64[LANES-1:0];
      bus.i_clear = ($urandom_range(0, 599) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    bus.i_we = 0; bus.i_re = 0; bus.i_clear = 0; rst = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
